circuit_cmd_writer: RTL

//  Upstream stage of the circuit drawer. Accepts a stream of circuit elements from the netlist parser, packs each into a
//  48-bit draw command, writes it into the processor RAM (1024x48) and counts it. On the last element it launches
//  the drawer (start_process/numCommands), waits for end_process, then reports completion.

---
 rtl/circuit_cmd_pkg.sv | 41 ++++
 rtl/cmd_pack.sv | 28 ++
 rtl/circuit_cmd_writer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/circuit_cmd_pkg.sv
// rtl/circuit_cmd_pkg.sv - shared constants, element type and FSM states for the circuit command writer
package circuit_cmd_pkg;

   localparam int MAX_CMDS = 1024;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [2:0] TYPE_WIRE      = 3'd0;
   localparam logic [2:0] TYPE_VSOURCE   = 3'd1;
   localparam logic [2:0] TYPE_CAPACITOR = 3'd2;
   localparam logic [2:0] TYPE_RESISTOR  = 3'd3;
   localparam logic [2:0] TYPE_DOT       = 3'd4;

   localparam int TYPE_MSB   = 47;
   localparam int TYPE_LSB   = 45;
   localparam int ORIENT_BIT = 44;
   localparam int X0_MSB     = 43;
   localparam int X0_LSB     = 34;
   localparam int Y0_MSB     = 33;
   localparam int Y0_LSB     = 25;
   localparam int X1_MSB     = 24;
   localparam int X1_LSB     = 15;
   localparam int Y1_MSB     = 14;
   localparam int Y1_LSB     = 6;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_COLLECT   = 3'd1;
   localparam logic [2:0] ST_LAUNCH    = 3'd2;
   localparam logic [2:0] ST_WAIT_DRAW = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   typedef struct packed {
      logic [2:0] etype;
      logic       orient;
      logic [9:0] x0;
      logic [8:0] y0;
      logic [9:0] x1;
      logic [8:0] y1;
   } element_t;

endpackage

// File: rtl/cmd_pack.sv
// rtl/cmd_pack.sv - combinational element-to-command packer and legality check
// CMDW_BOUNDS_CHECK_EN adds the on-screen coordinate check to the legality result.
module cmd_pack
   import circuit_cmd_pkg::*;
(
   input  element_t    elem,
   output logic [47:0] cmd,
   output logic        legal
);

   always_comb begin
      cmd = '0;
      cmd[TYPE_MSB:TYPE_LSB] = elem.etype;
      cmd[ORIENT_BIT]        = elem.orient;
      cmd[X0_MSB:X0_LSB]     = elem.x0;
      cmd[Y0_MSB:Y0_LSB]     = elem.y0;
      cmd[X1_MSB:X1_LSB]     = elem.x1;
      cmd[Y1_MSB:Y1_LSB]     = elem.y1;

      legal = (elem.etype <= TYPE_DOT);
`ifdef CMDW_BOUNDS_CHECK_EN
      if ((elem.x0 >= 10'(SCREEN_W)) || (elem.x1 >= 10'(SCREEN_W)) ||
          (elem.y0 >= 9'(SCREEN_H))  || (elem.y1 >= 9'(SCREEN_H)))
         legal = 1'b0;
`endif
   end

endmodule

// File: rtl/circuit_cmd_writer.sv
// rtl/circuit_cmd_writer.sv - packs parser elements into draw commands, writes them to RAM, launches the drawer
// Optional macro CMDW_BOUNDS_CHECK_EN enables screen bounds filtering inside cmd_pack.
module circuit_cmd_writer
   import circuit_cmd_pkg::*;
(
   input  logic        clk,
   input  logic        program_reset,
   input  logic        build_start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_type,
   input  logic        in_orient,
   input  logic [9:0]  in_x0,
   input  logic [9:0]  in_x1,
   input  logic [8:0]  in_y0,
   input  logic [8:0]  in_y1,
   input  logic        in_last,
   output logic [9:0]  processor_addr,
   output logic        processor_wren,
   output logic [47:0] processor_in,
   output logic        ram_owned,
   output logic [9:0]  numCommands,
   output logic        cmds_full,
   output logic        start_process,
   input  logic        end_process,
   output logic        build_done,
   output logic        overflow,
   output logic [9:0]  drop_count
);

   logic [2:0]  state;
   logic [10:0] count;
   logic        last_taken;
   logic        stg_valid;
   logic        stg_legal;
   logic        stg_last;
   logic [47:0] stg_cmd;

   element_t    elem;
   logic [47:0] packed_cmd;
   logic        elem_legal;
   logic        accept;
   logic        do_write;

   assign elem = '{etype: in_type, orient: in_orient, x0: in_x0, y0: in_y0, x1: in_x1, y1: in_y1};

   cmd_pack u_pack (
      .elem  (elem),
      .cmd   (packed_cmd),
      .legal (elem_legal)
   );

   // Once in_last is taken the parser is done; stop accepting until the next build.
   assign in_ready       = (state == ST_COLLECT) && !last_taken;
   assign accept         = in_valid && in_ready;
   assign cmds_full      = (count == 11'(MAX_CMDS));
   assign do_write       = stg_valid && stg_legal && !cmds_full;
   assign processor_wren = do_write;
   assign processor_addr = count[9:0];
   assign processor_in   = do_write ? stg_cmd : 48'd0;
   assign numCommands    = count[9:0];
   assign ram_owned      = (state == ST_COLLECT);
   assign start_process  = (state == ST_LAUNCH);
   assign build_done     = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (program_reset) begin
         state      <= ST_IDLE;
         count      <= '0;
         last_taken <= 1'b0;
         stg_valid  <= 1'b0;
         stg_legal  <= 1'b0;
         stg_last   <= 1'b0;
         stg_cmd    <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         stg_valid <= accept;
         if (accept) begin
            stg_cmd   <= packed_cmd;
            stg_legal <= elem_legal;
            stg_last  <= in_last;
         end

         if (do_write)
            count <= count + 11'd1;
         if (stg_valid && stg_legal && cmds_full)
            overflow <= 1'b1;
         if (stg_valid && !stg_legal && (drop_count != 10'h3FF))
            drop_count <= drop_count + 10'd1;

         // The final element's write lands in the last COLLECT cycle, so LAUNCH sees the final count.
         case (state)
            ST_IDLE: begin
               if (build_start) begin
                  state      <= ST_COLLECT;
                  count      <= '0;
                  overflow   <= 1'b0;
                  drop_count <= '0;
                  last_taken <= 1'b0;
               end
            end
            ST_COLLECT: begin
               if (accept && in_last)
                  last_taken <= 1'b1;
               if (stg_valid && stg_last)
                  state <= ST_LAUNCH;
            end
            ST_LAUNCH:    state <= ST_WAIT_DRAW;
            ST_WAIT_DRAW: if (end_process) state <= ST_DONE;
            ST_DONE: begin
               state      <= ST_IDLE;
               last_taken <= 1'b0;
            end
            default:      state <= ST_IDLE;
         endcase
      end
   end

endmodule
